// File: rtl/rv_pkg.sv
// Shared RV32 fetch/decode constants: base opcodes, canonical NOP and fetch FSM states.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    // Pointer width for a ring of the given depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding instruction words with their PCs; head is read straight from storage flops.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = ptr_w(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [31:0]   i_instr,
    input  logic [31:0]   i_pc,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic [31:0]   o_instr,
    output logic [31:0]   o_pc
);

    logic [DEPTH-1:0][31:0] mem_instr;
    logic [DEPTH-1:0][31:0] mem_pc;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   do_push;
    logic                   do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (count == '0);
    assign o_full  = (count == CW'(DEPTH));
    assign o_count = count;
    assign do_pop  = i_pop && !o_empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) begin
            mem_instr[wr_ptr] <= i_instr;
            mem_pc[wr_ptr]    <= i_pc;
        end
    end

    assign o_instr = o_empty ? NOP   : mem_instr[rd_ptr];
    assign o_pc    = o_empty ? '0    : mem_pc[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited request issue, in-order PC tracking, prefetch buffer and
// redirect handling that drains in-flight stale responses in FLUSH.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e           state, state_nxt;
    logic [31:0]            fpc;
    logic [CW-1:0]          outstanding, out_nxt;
    logic [CW-1:0]          drop_cnt, drop_nxt;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            in_flight;
    logic [DEPTH-1:0][31:0] pcq;
    logic [PW-1:0]          pcq_wr, pcq_rd;
    logic                   req_hs, rsp_ok, rsp_keep, pop, fifo_push;
    logic                   fifo_full, fifo_empty;
    logic                   unused_bits;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_bits = ^i_redirect_pc[1:0];

    // Slots are only freed by state already visible this cycle; a same-cycle pop gives no credit.
    assign in_flight        = {1'b0, outstanding} + {1'b0, fifo_count};
    assign o_imem_req_valid = i_rst_n && (state == RUN) && (in_flight < (CW+1)'(DEPTH));
    assign o_imem_addr      = fpc;

    assign req_hs    = o_imem_req_valid && i_imem_req_ready;
    assign rsp_ok    = i_imem_rsp_valid && (outstanding != '0);
    assign rsp_keep  = rsp_ok && (state == RUN) && !i_redirect_valid;
    assign pop       = o_instr_valid && i_instr_ready && !i_redirect_valid;
    assign fifo_push = rsp_keep && (!fifo_full || pop);
    assign o_instr_valid = !fifo_empty;

    always_comb begin
        out_nxt = outstanding;
        case ({req_hs, rsp_ok})
            2'b10:   out_nxt = outstanding + 1'b1;
            2'b01:   out_nxt = outstanding - 1'b1;
            default: out_nxt = outstanding;
        endcase
    end

    // drop_cnt is what remains in flight after this cycle, so a same-cycle response is not counted twice.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        case (state)
            RUN: begin
                if (i_redirect_valid) begin
                    drop_nxt = out_nxt;
                    if (out_nxt != '0) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (rsp_ok) begin
                    drop_nxt = drop_cnt - 1'b1;
                    if (drop_cnt == CW'(1)) state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= RUN;
            fpc         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            drop_cnt    <= drop_nxt;
            if (i_redirect_valid) fpc <= {i_redirect_pc[31:2], 2'b00};
            else if (req_hs)      fpc <= fpc + 32'd4;
            if (req_hs) pcq_wr <= inc(pcq_wr);
            if (rsp_ok) pcq_rd <= inc(pcq_rd);
        end
    end

    // PC queue tracks every outstanding request, stale or not, so it stays aligned with responses.
    always_ff @(posedge i_clk) begin
        if (req_hs) pcq[pcq_wr] <= fpc;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect_valid),
        .i_push  (fifo_push),
        .i_instr (i_imem_rsp_data),
        .i_pc    (pcq[pcq_rd]),
        .i_pop   (pop),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count),
        .o_instr (o_instr),
        .o_pc    (o_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: 1-cycle memory model with hold control, second instance for PC wrap.
module tb_instr_fetch;
    import rv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        req_ready, rsp_valid, redir, instr_ready;
    logic [31:0] rsp_data, redir_pc;
    logic        req_valid, instr_valid;
    logic [31:0] addr, instr, pc;
    logic        w_req_valid, w_rsp_valid, w_instr_valid;
    logic [31:0] w_addr, w_rsp_data, w_instr, w_pc;

    logic [31:0] pend[$], w_pend[$], got_pc[$], got_ins[$], w_addrs[$], w_got[$];
    int          n_tests, n_fail, n_req, tb_out;
    bit          mem_hold;

    always #5 i_clk = ~i_clk;

    instr_fetch dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_addr(addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .o_instr_valid(instr_valid), .i_instr_ready(instr_ready), .o_instr(instr), .o_pc(pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_req_valid(w_req_valid), .i_imem_req_ready(1'b1), .o_imem_addr(w_addr),
        .i_imem_rsp_valid(w_rsp_valid), .i_imem_rsp_data(w_rsp_data),
        .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
        .o_instr_valid(w_instr_valid), .i_instr_ready(1'b1), .o_instr(w_instr), .o_pc(w_pc)
    );

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory responses, record handshakes, advance to the next falling edge.
    task automatic step();
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        if (!mem_hold && pend.size() != 0) begin
            a_rsp_proto: assert (tb_out > 0);
            rsp_valid = 1'b1;
            rsp_data  = memdata(pend.pop_front());
            tb_out--;
        end
        w_rsp_valid = 1'b0;
        w_rsp_data  = 32'h0;
        if (w_pend.size() != 0) begin
            w_rsp_valid = 1'b1;
            w_rsp_data  = memdata(w_pend.pop_front());
        end
        #1;
        if (req_valid && req_ready) begin
            pend.push_back(addr);
            n_req++;
            tb_out++;
        end
        if (instr_valid && instr_ready && !redir) begin
            got_pc.push_back(pc);
            got_ins.push_back(instr);
        end
        if (w_req_valid) begin
            w_pend.push_back(w_addr);
            w_addrs.push_back(w_addr);
        end
        if (w_instr_valid) w_got.push_back(w_pc);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        req_ready = 1'b1; instr_ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        rsp_valid = 1'b0; rsp_data = 32'h0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
        mem_hold = 1'b0; n_req = 0; tb_out = 0;
        pend.delete(); w_pend.delete(); got_pc.delete(); got_ins.delete();
        w_addrs.delete(); w_got.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
    endtask

    task automatic run_until(input int want, input int budget);
        for (int i = 0; i < budget && got_pc.size() < want; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        i_rst_n = 1'b1; req_ready = 1'b0; instr_ready = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        rsp_valid = 1'b0; rsp_data = 32'h0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
        mem_hold = 1'b0; tb_out = 0; n_req = 0;
        #3 i_rst_n = 1'b0;
        #1;
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'h0);

        // Sequential fetch
        do_reset();
        chk("seq_first_req", {31'b0, req_valid}, 32'd1);
        chk("seq_first_addr", addr, 32'h0);
        step();
        chk("seq_no_bypass", {31'b0, instr_valid}, 32'd0);
        step();
        chk("seq_fill_valid", {31'b0, instr_valid}, 32'd1);
        chk("seq_fill_pc", pc, 32'h0);
        run_until(4, 30);
        chk("seq_count", 32'(got_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_pc.size()) begin
                chk($sformatf("seq_pc%0d", i), got_pc[i], 32'(i * 4));
                chk($sformatf("seq_ins%0d", i), got_ins[i], memdata(32'(i * 4)));
            end
        chk("wrap_count", 32'(w_addrs.size() >= 3), 32'd1);
        if (w_addrs.size() >= 3) begin
            chk("wrap_a0", w_addrs[0], 32'hFFFF_FFF8);
            chk("wrap_a1", w_addrs[1], 32'hFFFF_FFFC);
            chk("wrap_a2", w_addrs[2], 32'h0000_0000);
        end
        if (w_got.size() >= 1) chk("wrap_pc0", w_got[0], 32'hFFFF_FFF8);
        else chk("wrap_got", 32'(w_got.size()), 32'd1);

        // Decode backpressure
        do_reset();
        instr_ready = 1'b0;
        repeat (10) step();
        chk("bp_reqs", 32'(n_req), 32'd2);
        chk("bp_req_valid", {31'b0, req_valid}, 32'd0);
        chk("bp_valid", {31'b0, instr_valid}, 32'd1);
        chk("bp_head_pc", pc, 32'h0);
        chk("bp_head_ins", instr, memdata(32'h0));
        instr_ready = 1'b1;
        step();
        chk("bp_next_pc", pc, 32'h4);
        run_until(4, 30);
        for (int i = 0; i < 4; i++)
            if (i < got_pc.size()) chk($sformatf("bp_pc%0d", i), got_pc[i], 32'(i * 4));
        chk("bp_count", 32'(got_pc.size() >= 4), 32'd1);

        // Redirect with two outstanding requests
        do_reset();
        mem_hold = 1'b1;
        step(); step();
        chk("rd_credit_stop", {31'b0, req_valid}, 32'd0);
        redir = 1'b1; redir_pc = 32'h0000_0103;
        step();
        redir = 1'b0;
        chk("rd_addr", addr, 32'h0000_0100);
        chk("rd_flush_noreq", {31'b0, req_valid}, 32'd0);
        mem_hold = 1'b0;
        step();
        chk("rd_flush_hold", {31'b0, req_valid}, 32'd0);
        step();
        chk("rd_run_req", {31'b0, req_valid}, 32'd1);
        chk("rd_run_addr", addr, 32'h0000_0100);
        chk("rd_no_stale", 32'(got_pc.size()), 32'd0);
        run_until(1, 20);
        if (got_pc.size() >= 1) begin
            chk("rd_first_pc", got_pc[0], 32'h0000_0100);
            chk("rd_first_ins", got_ins[0], memdata(32'h0000_0100));
        end else chk("rd_got", 32'(got_pc.size()), 32'd1);

        // Redirect, response and decode handshake in the same cycle
        do_reset();
        instr_ready = 1'b0;
        step(); step();
        chk("sim_pre_valid", {31'b0, instr_valid}, 32'd1);
        chk("sim_pre_pc", pc, 32'h0);
        instr_ready = 1'b1; redir = 1'b1; redir_pc = 32'h0000_0200;
        step();
        redir = 1'b0;
        chk("sim_valid", {31'b0, instr_valid}, 32'd0);
        chk("sim_req", {31'b0, req_valid}, 32'd1);
        chk("sim_addr", addr, 32'h0000_0200);
        run_until(1, 20);
        if (got_pc.size() >= 1) chk("sim_first_pc", got_pc[0], 32'h0000_0200);
        else chk("sim_got", 32'(got_pc.size()), 32'd1);

        // Reset asserted while flushing
        do_reset();
        mem_hold = 1'b1;
        step(); step();
        redir = 1'b1; redir_pc = 32'h0000_0300;
        step();
        redir = 1'b0;
        chk("rf_pre_addr", addr, 32'h0000_0300);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rf_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rf_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rf_instr", instr, NOP);
        chk("rf_pc", pc, 32'h0);
        chk("rf_addr", addr, 32'h0);
        do_reset();
        chk("rf_post_req", {31'b0, req_valid}, 32'd1);
        chk("rf_post_addr", addr, 32'h0);
        run_until(1, 20);
        if (got_pc.size() >= 1) chk("rf_first_pc", got_pc[0], 32'h0);
        else chk("rf_got", 32'(got_pc.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
